// File: rtl/dlatch_if.sv
// Signal bundle for the dlatch bank: data/enable in, both latch copies and
// their complements out, plus the optional cross-check monitor results.
interface dlatch_if #(
    parameter int W     = 1,
    parameter int CNT_W = 8
);
    logic [W-1:0]     D;
    logic             EN;
    logic [W-1:0]     Y_b;
    logic [W-1:0]     notY_b;
    logic [W-1:0]     Y_nb;
    logic [W-1:0]     notY_nb;
    logic             mismatch;
    logic [CNT_W-1:0] mismatch_cnt;

    modport master (
        output D,
        output EN,
        input  Y_b,
        input  notY_b,
        input  Y_nb,
        input  notY_nb,
        input  mismatch,
        input  mismatch_cnt
    );

    modport slave (
        input  D,
        input  EN,
        output Y_b,
        output notY_b,
        output Y_nb,
        output notY_nb,
        output mismatch,
        output mismatch_cnt
    );
endinterface

// File: rtl/dlatch.sv
// Level-sensitive D-latch bank coded twice (blocking and non-blocking) as an
// equivalence pair; define DLATCH_MONITOR_EN to build the clocked cross-check monitor.
module dlatch #(
    parameter int W     = 1,
    parameter int CNT_W = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    dlatch_if.slave  bus
);

    logic [W-1:0] y_b_r;
    logic [W-1:0] y_nb_r;

    // Blocking-style latch: reset dominates, transparent while EN is high
    always_latch begin
        if (!rst_n) begin
            y_b_r = {W{1'b0}};
        end else if (bus.EN) begin
            y_b_r = bus.D;
        end
    end

    // Non-blocking-style latch: same structure as the blocking copy
    always_latch begin
        if (!rst_n) begin
            y_nb_r <= {W{1'b0}};
        end else if (bus.EN) begin
            y_nb_r <= bus.D;
        end
    end

    // Complements come from the stored state so they can never drift apart
    assign bus.Y_b     = y_b_r;
    assign bus.notY_b  = ~y_b_r;
    assign bus.Y_nb    = y_nb_r;
    assign bus.notY_nb = ~y_nb_r;

`ifdef DLATCH_MONITOR_EN
    logic             diff_s;
    logic             mismatch_r;
    logic [CNT_W-1:0] mismatch_cnt_r;

    // Compare the port-level values so anything disturbing the outputs is caught
    assign diff_s = (bus.Y_b != bus.Y_nb) || (bus.notY_b != bus.notY_nb);

    // Sticky flag and saturating count of clocks on which the copies disagree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_r     <= 1'b0;
            mismatch_cnt_r <= {CNT_W{1'b0}};
        end else if (diff_s) begin
            mismatch_r <= 1'b1;
            if (mismatch_cnt_r != {CNT_W{1'b1}}) begin
                mismatch_cnt_r <= mismatch_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                mismatch_cnt_r <= mismatch_cnt_r;
            end
        end else begin
            mismatch_r     <= mismatch_r;
            mismatch_cnt_r <= mismatch_cnt_r;
        end
    end

    assign bus.mismatch     = mismatch_r;
    assign bus.mismatch_cnt = mismatch_cnt_r;
`else
    logic unused_clk_s;

    assign unused_clk_s     = clk;
    assign bus.mismatch     = 1'b0;
    assign bus.mismatch_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_dlatch.sv
// Table-driven bench for dlatch with a scoreboard queue of expected outputs;
// hand sequences cover the EN-fall capture edge, forced disagreement and async reset.
module tb_dlatch;
    localparam int W     = 1;
    localparam int CNT_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    dlatch_if #(.W(W), .CNT_W(CNT_W)) bus ();

    dlatch #(.W(W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         en;
        logic [W-1:0] d;
        logic [W-1:0] y;
    } vec_t;

    typedef struct {
        logic [W-1:0]     y;
        logic             mm;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

`ifdef DLATCH_MONITOR_EN
    localparam logic             MON_MM  = 1'b1;
    localparam logic [CNT_W-1:0] MON_CNT = 8'd3;
`else
    localparam logic             MON_MM  = 1'b0;
    localparam logic [CNT_W-1:0] MON_CNT = 8'd0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic [W-1:0] d, input logic [W-1:0] y);
        vec_t v;
        v.rst = r; v.en = e; v.d = d; v.y = y;
        vecs.push_back(v);
    endtask

    task automatic push_exp(input logic [W-1:0] y);
        exp_t e;
        e.y = y; e.mm = 1'b0; e.cnt = {CNT_W{1'b0}};
        sb.push_back(e);
    endtask

    task automatic compare_out(input string tag);
        exp_t         e;
        logic [W-1:0] ny;
        if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got nothing, expected an entry", tag);
        end else begin
            e  = sb.pop_front();
            ny = ~e.y;
            check({tag, " Y_b"},          32'(bus.Y_b),          32'(e.y));
            check({tag, " notY_b"},       32'(bus.notY_b),       32'(ny));
            check({tag, " Y_nb"},         32'(bus.Y_nb),         32'(e.y));
            check({tag, " notY_nb"},      32'(bus.notY_nb),      32'(ny));
            check({tag, " mismatch"},     32'(bus.mismatch),     32'(e.mm));
            check({tag, " mismatch_cnt"}, 32'(bus.mismatch_cnt), 32'(e.cnt));
        end
    endtask

    // D and EN are never changed in the same time step; order depends on EN direction
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst_n = v.rst;
        if (v.en) begin
            bus.D = v.d;
            #1;
            bus.EN = 1'b1;
        end else begin
            bus.EN = 1'b0;
            #1;
            bus.D = v.d;
        end
        push_exp(v.y);
        #2;
        compare_out(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] fv;
        bus.D  = 1'b0;
        bus.EN = 1'b0;

        // reset has priority, then release with EN high
        add(1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1);
        // latch cycle, twice
        for (int k = 0; k < 2; k++) begin
            add(1'b1, 1'b1, 1'b0, 1'b0);
            add(1'b1, 1'b0, 1'b0, 1'b0);
            add(1'b1, 1'b1, 1'b1, 1'b1);
            add(1'b1, 1'b0, 1'b1, 1'b1);
        end
        // toggle while transparent
        add(1'b1, 1'b1, 1'b1, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1'b0);
        // toggle while holding a 1
        add(1'b1, 1'b1, 1'b1, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b1);
        // reset while holding, release with EN low keeps 0 until EN rises
        add(1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1);

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // EN falls, D changes one unit later: the pre-change value is held
        @(negedge clk);
        bus.D  = 1'b0;
        #1;
        bus.EN = 1'b0;
        #1;
        bus.D  = 1'b1;
        push_exp(1'b0);
        #1;
        compare_out("capture_edge");

        @(negedge clk);
        bus.D  = 1'b1;
        #1;
        bus.EN = 1'b1;
        #1;
        bus.EN = 1'b0;
        #1;
        bus.D  = 1'b0;
        push_exp(1'b1);
        #1;
        compare_out("capture_edge2");

        // disturb the non-blocking output for exactly three monitor clocks
        @(negedge clk);
        fv = ~bus.Y_b;
        force bus.Y_nb = fv;
        repeat (3) @(posedge clk);
        #1;
        release bus.Y_nb;
        @(negedge clk);
        check("force mismatch",     32'(bus.mismatch),     32'(MON_MM));
        check("force mismatch_cnt", 32'(bus.mismatch_cnt), 32'(MON_CNT));
        check("release Y_nb",       32'(bus.Y_nb),         32'(1'b1));
        @(negedge clk);
        check("sticky mismatch",     32'(bus.mismatch),     32'(MON_MM));
        check("sticky mismatch_cnt", 32'(bus.mismatch_cnt), 32'(MON_CNT));

        // asynchronous reset between clock edges clears the monitor at once
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst mismatch",     32'(bus.mismatch),     32'(1'b0));
        check("async rst mismatch_cnt", 32'(bus.mismatch_cnt), 32'(0));
        check("async rst Y_b",          32'(bus.Y_b),          32'(1'b0));
        check("async rst notY_nb",      32'(bus.notY_nb),      32'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post rst mismatch", 32'(bus.mismatch), 32'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
